// File: rtl/mmm_r4_word_sched_if.sv
// Control bundle between the radix-4 Montgomery word scheduler and the PE kernel.
// The master side is the scheduler, and the slave side is the kernel or its controller.
interface mmm_r4_word_sched_if #(
  parameter int AW = 7,
  parameter int DW = 10,
  parameter int P  = 4
) ();
  logic          start;
  logic          busy;
  logic          word_vld;
  logic [AW-1:0] word_idx;
  logic          first_pass;
  logic          last_pass;
  logic [DW-1:0] digit_base;
  logic [P-1:0]  digit_en;
  logic          done;

  modport master (
    input  start,
    output busy, word_vld, word_idx, first_pass, last_pass, digit_base, digit_en, done
  );

  modport slave (
    output start,
    input  busy, word_vld, word_idx, first_pass, last_pass, digit_base, digit_en, done
  );
endinterface

// File: rtl/mmm_r4_word_sched.sv
// Word-serial scheduler for a P-PE radix-4 Montgomery kernel: issues W-bit words per pass,
// pads short passes so that a pass never outruns the PE chain, and then drains the chain.
module mmm_r4_word_sched #(
  parameter int K = 1024,
  parameter int W = 16,
  parameter int P = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mmm_r4_word_sched_if.master  bus
);
  localparam int NW    = K / W + 1;
  localparam int NIT   = K / 2 + 1;
  localparam int NPASS = (NIT + P - 1) / P;
  localparam int L     = (NW > 2 * P) ? NW : 2 * P;
  localparam int AW    = $clog2(NW);
  localparam int DW    = $clog2(NIT);
  localparam int CW    = $clog2(L + 1);
  localparam int PW    = $clog2(NPASS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] pass_q, pass_d;

  logic word_end, gap_end, drain_end, pass_last;
  logic in_pass, active;
  int   base_full;

  assign word_end  = (cyc_q == CW'(NW - 1));
  assign gap_end   = (cyc_q == CW'(L - 1));
  assign drain_end = (cyc_q == CW'(2 * P - 1));
  assign pass_last = (pass_q == PW'(NPASS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
    end
  end

  // cyc_q counts cycles within a pass (ISSUE + GAP) and is reused as the drain counter
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        pass_d = '0;
        if (bus.start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!word_end) begin
          cyc_d = cyc_q + CW'(1);
        end else if (L > NW) begin
          state_d = S_GAP;
          cyc_d   = cyc_q + CW'(1);
        end else if (pass_last) begin
          state_d = S_DRAIN;
          cyc_d   = '0;
        end else begin
          pass_d = pass_q + PW'(1);
          cyc_d  = '0;
        end
      end
      S_GAP: begin
        if (!gap_end) begin
          cyc_d = cyc_q + CW'(1);
        end else if (pass_last) begin
          state_d = S_DRAIN;
          cyc_d   = '0;
        end else begin
          state_d = S_ISSUE;
          pass_d  = pass_q + PW'(1);
          cyc_d   = '0;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        pass_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        pass_d  = '0;
      end
    endcase
  end

  // Pass-level controls stay valid through DRAIN because pass_q is not cleared until DONE
  always_comb begin
    in_pass   = (state_q == S_ISSUE) || (state_q == S_GAP);
    active    = in_pass || (state_q == S_DRAIN);
    base_full = active ? int'(pass_q) * P : 0;

    bus.busy       = (state_q != S_IDLE);
    bus.word_vld   = (state_q == S_ISSUE);
    bus.done       = (state_q == S_DONE);
    bus.first_pass = active && (pass_q == '0);
    bus.last_pass  = active && pass_last;
    bus.digit_base = DW'(base_full);

    bus.word_idx = '0;
    if (state_q == S_ISSUE)    bus.word_idx = AW'(cyc_q);
    else if (state_q == S_GAP) bus.word_idx = AW'(NW - 1);

    bus.digit_en = '0;
    for (int i = 0; i < P; i++) begin
      bus.digit_en[i] = active && ((base_full + i) < NIT);
    end
  end
endmodule

// File: tb/tb_mmm_r4_word_sched.sv
// Directed bench for mmm_r4_word_sched with three configurations: a short operand with gaps,
// a long operand without gaps, and an operand whose digit count is an exact multiple of P.
module tb_mmm_r4_word_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // A: K=16 W=8 P=4 -> NW=3 NIT=9 NPASS=3 L=8
  mmm_r4_word_sched_if #(.AW(2), .DW(4), .P(4)) ifa ();
  mmm_r4_word_sched #(.K(16), .W(8), .P(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  // B: K=64 W=8 P=2 -> NW=9 NIT=33 NPASS=17 L=9
  mmm_r4_word_sched_if #(.AW(4), .DW(6), .P(2)) ifb ();
  mmm_r4_word_sched #(.K(64), .W(8), .P(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
  // C: K=16 W=8 P=3 -> NW=3 NIT=9 NPASS=3 L=6
  mmm_r4_word_sched_if #(.AW(2), .DW(4), .P(3)) ifc ();
  mmm_r4_word_sched #(.K(16), .W(8), .P(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc.master));

  logic [14:0] snap_a;
  logic [16:0] snap_b;
  logic [13:0] snap_c;
  assign snap_a = {ifa.busy, ifa.word_vld, ifa.word_idx, ifa.first_pass, ifa.last_pass,
                   ifa.digit_base, ifa.digit_en, ifa.done};
  assign snap_b = {ifb.busy, ifb.word_vld, ifb.word_idx, ifb.first_pass, ifb.last_pass,
                   ifb.digit_base, ifb.digit_en, ifb.done};
  assign snap_c = {ifc.busy, ifc.word_vld, ifc.word_idx, ifc.first_pass, ifc.last_pass,
                   ifc.digit_base, ifc.digit_en, ifc.done};

  // Expected A outputs in cycle c, where c=1 is the cycle that carries word 0 of pass 0
  function automatic logic [14:0] exp_a(int c);
    logic [14:0] e;
    int pass, off;
    e = '0;
    if (c >= 1 && c <= 24) begin
      pass = (c - 1) / 8;
      off  = (c - 1) % 8;
      e[14]    = 1'b1;
      e[13]    = (off < 3);
      e[12:11] = (off < 3) ? 2'(off) : 2'd2;
      e[10]    = (pass == 0);
      e[9]     = (pass == 2);
      e[8:5]   = 4'(pass * 4);
      e[4:1]   = (pass == 2) ? 4'b0001 : 4'b1111;
    end else if (c >= 25 && c <= 32) begin
      e[14]  = 1'b1;
      e[9]   = 1'b1;
      e[8:5] = 4'd8;
      e[4:1] = 4'b0001;
    end else if (c == 33) begin
      e[14] = 1'b1;
      e[0]  = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (snap_a !== '0) begin bad++; $display("FAIL reset_a got=%h exp=0", snap_a); end
    total++;
    if (snap_b !== '0) begin bad++; $display("FAIL reset_b got=%h exp=0", snap_b); end
    total++;
    if (snap_c !== '0) begin bad++; $display("FAIL reset_c got=%h exp=0", snap_c); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (snap_a !== '0) begin bad++; $display("FAIL idle_a got=%h exp=0", snap_a); end
  endtask

  task automatic test_short_stall();
    logic [14:0] got;
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      got = snap_a;
      if (c >= 25 && c <= 32) got[12:11] = 2'b00;
      total++;
      if (got !== exp_a(c)) begin
        bad++;
        $display("FAIL short_stall c=%0d got=%h exp=%h", c, got, exp_a(c));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      total++;
      if (snap_a !== exp_a(c)) begin
        bad++;
        $display("FAIL pre_reset c=%0d got=%h exp=%h", c, snap_a, exp_a(c));
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (snap_a !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", snap_a); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (snap_a !== '0) begin bad++; $display("FAIL post_reset c=%0d got=%h exp=0", c, snap_a); end
    end
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      got = snap_a;
      if (c >= 25 && c <= 32) got[12:11] = 2'b00;
      total++;
      if (got !== exp_a(c)) begin
        bad++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp_a(c));
      end
    end
  endtask

  task automatic test_long_nogap();
    logic [16:0] got, e;
    int pass, off;
    @(posedge clk); #1 ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      got = snap_b;
      e   = '0;
      if (c <= 153) begin
        pass = (c - 1) / 9;
        off  = (c - 1) % 9;
        e[16]    = 1'b1;
        e[15]    = 1'b1;
        e[14:11] = 4'(off);
        e[10]    = (pass == 0);
        e[9]     = (pass == 16);
        e[8:3]   = 6'(pass * 2);
        e[2:1]   = (pass == 16) ? 2'b01 : 2'b11;
      end else if (c <= 157) begin
        got[14:11] = 4'd0;
        e[16]  = 1'b1;
        e[9]   = 1'b1;
        e[8:3] = 6'd32;
        e[2:1] = 2'b01;
      end else if (c == 158) begin
        e[16] = 1'b1;
        e[0]  = 1'b1;
      end
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL long_nogap c=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_exact_multiple();
    logic [13:0] got, e;
    int pass, off;
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      got = snap_c;
      e   = '0;
      if (c <= 18) begin
        pass = (c - 1) / 6;
        off  = (c - 1) % 6;
        e[13]    = 1'b1;
        e[12]    = (off < 3);
        e[11:10] = (off < 3) ? 2'(off) : 2'd2;
        e[9]     = (pass == 0);
        e[8]     = (pass == 2);
        e[7:4]   = 4'(pass * 3);
        e[3:1]   = 3'b111;
      end else if (c <= 24) begin
        got[11:10] = 2'd0;
        e[13]  = 1'b1;
        e[8]   = 1'b1;
        e[7:4] = 4'd6;
        e[3:1] = 3'b111;
      end else if (c == 25) begin
        e[13] = 1'b1;
        e[0]  = 1'b1;
      end
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL exact_multiple c=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [14:0] got;
    int ndone = 0;
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      got = snap_a;
      if (c >= 25 && c <= 32) got[12:11] = 2'b00;
      if (ifa.done === 1'b1) ndone++;
      total++;
      if (got !== exp_a(c)) begin
        bad++;
        $display("FAIL start_busy c=%0d got=%h exp=%h", c, got, exp_a(c));
      end
      ifa.start = (c == 9);
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", ndone); end
  endtask

  initial begin
    test_reset();
    test_short_stall();
    test_reset_mid();
    test_long_nogap();
    test_exact_multiple();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
